// File: rtl/apb_reg_bridge_if.sv
// APB completer-side bus bundle for apb_reg_bridge.
// Optional byte strobes (pstrb) exist only when APB_BRIDGE_PSTRB_EN is defined.
interface apb_reg_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
`ifdef APB_BRIDGE_PSTRB_EN
    logic [DATA_W/8-1:0] pstrb;
`endif
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
`ifdef APB_BRIDGE_PSTRB_EN
        output pstrb,
`endif
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
`ifdef APB_BRIDGE_PSTRB_EN
        input  pstrb,
`endif
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_reg_bridge.sv
// apb_reg_bridge: APB completer bridging transfers onto a request/acknowledge
// register backend. Latches the address (and write data) in the setup phase,
// rejects misaligned addresses, holds wr_en/rd_en until the backend acks,
// errors or the wait-state timeout expires, then answers with a single-cycle
// registered pready/pslverr.
// Optional feature: define APB_BRIDGE_PSTRB_EN to add APB4 byte strobes
// (pstrb in, wstrb out); a write with all strobes clear completes as a no-op.
module apb_reg_bridge #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                rst,
    apb_reg_bridge_if.slave     apb,
    output logic                wr_en,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   addr,
    output logic [DATA_W-1:0]   wdata,
`ifdef APB_BRIDGE_PSTRB_EN
    output logic [DATA_W/8-1:0] wstrb,
`endif
    input  logic [DATA_W-1:0]   rdata,
    input  logic                wack,
    input  logic                rack,
    input  logic                waddrerr,
    input  logic                raddrerr
);

    // Number of byte-offset address bits that must be zero for an aligned access.
    localparam int LSB_W = $clog2(DATA_W / 8);
    localparam int LOW_W = (LSB_W > 0) ? LSB_W : 1;

    // Wait-state counter; one bit minimum so a disabled timeout still elaborates.
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_reg,   state_next;
    logic [CNT_W-1:0]    cnt_reg,     cnt_next;
    logic                dir_reg,     dir_next;
    logic [ADDR_W-1:0]   addr_reg,    addr_next;
    logic [DATA_W-1:0]   wdata_reg,   wdata_next;
    logic [DATA_W-1:0]   prdata_reg,  prdata_next;
    logic                pready_reg,  pready_next;
    logic                pslverr_reg, pslverr_next;
    logic                wr_en_reg,   wr_en_next;
    logic                rd_en_reg,   rd_en_next;
`ifdef APB_BRIDGE_PSTRB_EN
    logic [DATA_W/8-1:0] wstrb_reg,   wstrb_next;
`endif

    logic [LOW_W-1:0]    low_bits;
    logic                misaligned;
    logic                strb_noop;
    logic                hit_err;
    logic                hit_ack;
    logic                timed_out;

    // Gather the byte-offset address bits; an 8-bit bus has none.
    genvar gi;
    generate
        if (LSB_W == 0) begin : g_no_low
            assign low_bits = '0;
        end else begin : g_low
            for (gi = 0; gi < LSB_W; gi++) begin : g_bit
                assign low_bits[gi] = apb.paddr[gi];
            end
        end
    endgenerate

    assign misaligned = |low_bits;

`ifdef APB_BRIDGE_PSTRB_EN
    assign strb_noop = apb.pwrite && (apb.pstrb == '0);
`else
    assign strb_noop = 1'b0;
`endif

    // Only the acknowledge/error belonging to the latched direction counts.
    assign hit_err   = dir_reg ? waddrerr : raddrerr;
    assign hit_ack   = dir_reg ? wack     : rack;
    assign timed_out = (TIMEOUT_CYC != 0) && (cnt_reg == CNT_LIMIT);

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            dir_reg     <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            prdata_reg  <= '0;
            pready_reg  <= 1'b0;
            pslverr_reg <= 1'b0;
            wr_en_reg   <= 1'b0;
            rd_en_reg   <= 1'b0;
`ifdef APB_BRIDGE_PSTRB_EN
            wstrb_reg   <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            dir_reg     <= dir_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            prdata_reg  <= prdata_next;
            pready_reg  <= pready_next;
            pslverr_reg <= pslverr_next;
            wr_en_reg   <= wr_en_next;
            rd_en_reg   <= rd_en_next;
`ifdef APB_BRIDGE_PSTRB_EN
            wstrb_reg   <= wstrb_next;
`endif
        end
    end

    // Next-state and next-output decode; pready and the enables default low
    // so each is a one-state-wide pulse.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        dir_next     = dir_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        prdata_next  = prdata_reg;
        pready_next  = 1'b0;
        pslverr_next = 1'b0;
        wr_en_next   = 1'b0;
        rd_en_next   = 1'b0;
`ifdef APB_BRIDGE_PSTRB_EN
        wstrb_next   = wstrb_reg;
`endif

        unique case (state_reg)
            IDLE: begin
                if (apb.psel && !apb.penable) begin
                    addr_next = apb.paddr;
                    dir_next  = apb.pwrite;
                    cnt_next  = '0;
                    if (apb.pwrite) begin
                        wdata_next = apb.pwdata;
                    end
`ifdef APB_BRIDGE_PSTRB_EN
                    wstrb_next = apb.pwrite ? apb.pstrb : '0;
`endif
                    if (misaligned) begin
                        // Reject without touching the backend.
                        state_next   = RESP;
                        pready_next  = 1'b1;
                        pslverr_next = 1'b1;
                        prdata_next  = '0;
                    end else if (strb_noop) begin
                        // Nothing to write: complete cleanly, backend untouched.
                        state_next   = RESP;
                        pready_next  = 1'b1;
                        pslverr_next = 1'b0;
                        prdata_next  = '0;
                    end else begin
                        state_next = REQ;
                        wr_en_next = apb.pwrite;
                        rd_en_next = !apb.pwrite;
                    end
                end
            end

            REQ: begin
                if (!apb.psel) begin
                    // Master abandoned the transfer: drop the request, no response.
                    state_next = IDLE;
                end else if (hit_err) begin
                    state_next   = RESP;
                    pready_next  = 1'b1;
                    pslverr_next = 1'b1;
                    prdata_next  = '0;
                end else if (hit_ack) begin
                    state_next   = RESP;
                    pready_next  = 1'b1;
                    pslverr_next = 1'b0;
                    prdata_next  = dir_reg ? '0 : rdata;
                end else if (timed_out) begin
                    state_next   = RESP;
                    pready_next  = 1'b1;
                    pslverr_next = 1'b1;
                    prdata_next  = '0;
                end else begin
                    // Still waiting: keep requesting and count the stall.
                    wr_en_next = dir_reg;
                    rd_en_next = !dir_reg;
                    if (cnt_reg != CNT_MAX) begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end

            RESP: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign apb.prdata  = prdata_reg;
    assign apb.pready  = pready_reg;
    assign apb.pslverr = pslverr_reg;
    assign wr_en       = wr_en_reg;
    assign rd_en       = rd_en_reg;
    assign addr        = addr_reg;
    assign wdata       = wdata_reg;
`ifdef APB_BRIDGE_PSTRB_EN
    assign wstrb       = wstrb_reg;
`endif

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Self-checking bench for apb_reg_bridge (32-bit data, TIMEOUT_CYC=4).
// Directed steps followed by randomized transfers checked against a
// transaction-level model of the bridge's response rules.
module tb_apb_reg_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;
`ifdef APB_BRIDGE_PSTRB_EN
    localparam bit PSTRB_EN = 1'b1;
`else
    localparam bit PSTRB_EN = 1'b0;
`endif

    // Backend behaviour per transfer.
    localparam int M_ACK   = 0;  // matching ack at cycle 'delay'
    localparam int M_ERR   = 1;  // matching error at cycle 'delay'
    localparam int M_BOTH  = 2;  // ack and error together at cycle 'delay'
    localparam int M_NONE  = 3;  // backend never answers
    localparam int M_WRONG = 4;  // only the opposite direction's ack/error, every cycle

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    apb_reg_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    logic          wr_en, rd_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rdata;
    logic          wack, rack, waddrerr, raddrerr;
`ifdef APB_BRIDGE_PSTRB_EN
    logic [3:0]    wstrb;
`endif

    apb_reg_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .apb      (bus),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .addr     (addr),
        .wdata    (wdata),
`ifdef APB_BRIDGE_PSTRB_EN
        .wstrb    (wstrb),
`endif
        .rdata    (rdata),
        .wack     (wack),
        .rack     (rack),
        .waddrerr (waddrerr),
        .raddrerr (raddrerr)
    );

    int tests = 0;
    int fails = 0;

    // Observations from the last transfer.
    logic        o_got, o_err, o_both, o_rdy_after, o_en_at_resp;
    int          o_waits, o_req;
    logic [31:0] o_prdata, o_addr, o_wdata;
    logic [3:0]  o_wstrb;

    // Model expectations.
    int          e_req;
    logic        e_err;
    logic [31:0] e_prdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_backend();
        wack = 1'b0; rack = 1'b0; waddrerr = 1'b0; raddrerr = 1'b0;
    endtask

    // Transaction-level model: how many request cycles the backend sees, and
    // what the completer answers.
    task automatic model(input logic wr, input logic [31:0] a, input logic [3:0] strb,
                         input int mode, input int delay, input logic [31:0] rd);
        e_prdata = 32'h0;
        if (a[1:0] != 2'b00) begin
            e_req = 0; e_err = 1'b1;
        end else if (PSTRB_EN && wr && strb == 4'h0) begin
            e_req = 0; e_err = 1'b0;
        end else if (mode == M_NONE || mode == M_WRONG || delay > TO) begin
            e_req = TO + 1; e_err = 1'b1;
        end else begin
            e_req = delay + 1;
            e_err = (mode != M_ACK);
            if (!wr && mode == M_ACK) e_prdata = rd;
        end
    endtask

    // One complete APB transfer with a scripted backend.
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] strb, input int mode, input int delay,
                        input logic [31:0] rd);
        o_got = 1'b0; o_err = 1'bx; o_both = 1'b0; o_en_at_resp = 1'b0;
        o_waits = 0; o_req = 0; o_prdata = 'x; o_addr = 'x; o_wdata = 'x; o_wstrb = 'x;
        @(negedge clk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = a; bus.pwdata = d;
`ifdef APB_BRIDGE_PSTRB_EN
        bus.pstrb = strb;
`endif
        @(negedge clk);
        bus.penable = 1'b1;
        for (int c = 0; c < 64; c++) begin
            if (c > 0) @(negedge clk);
            clear_backend();
            rdata = $urandom;
            if (wr_en && rd_en) o_both = 1'b1;
            if (bus.pready) begin
                o_got = 1'b1; o_err = bus.pslverr; o_prdata = bus.prdata;
                o_en_at_resp = wr_en | rd_en;
                break;
            end
            o_waits++;
            if (wr_en || rd_en) begin
                if (o_req == 0) begin
                    o_addr = addr; o_wdata = wdata;
`ifdef APB_BRIDGE_PSTRB_EN
                    o_wstrb = wstrb;
`endif
                end
                if (mode == M_WRONG) begin
                    if (wr) begin rack = 1'b1; raddrerr = 1'b1; end
                    else    begin wack = 1'b1; waddrerr = 1'b1; end
                end else if (o_req == delay && mode != M_NONE) begin
                    if (mode != M_ERR) begin
                        if (wr) wack = 1'b1; else rack = 1'b1;
                    end
                    if (mode != M_ACK) begin
                        if (wr) waddrerr = 1'b1; else raddrerr = 1'b1;
                    end
                    rdata = rd;
                end
                o_req++;
            end
        end
        @(negedge clk);
        o_rdy_after = bus.pready;
        clear_backend();
        bus.psel = 1'b0; bus.penable = 1'b0;
    endtask

    // Run one transfer and compare it against the model; one line per transfer.
    task automatic run_case(input string name, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] strb, input int mode,
                            input int delay, input logic [31:0] rd);
        xfer(wr, a, d, strb, mode, delay, rd);
        model(wr, a, strb, mode, delay, rd);
        $display("[TB] %s wr=%0d addr=%08h mode=%0d delay=%0d -> req=%0d err=%0d prdata=%08h",
                 name, wr, a, mode, delay, o_req, o_err, o_prdata);
        check({name, "_done"},     o_got, 1'b1);
        check({name, "_pslverr"},  o_err, e_err);
        check({name, "_waits"},    o_waits, e_req);
        check({name, "_reqcyc"},   o_req, e_req);
        check({name, "_excl"},     o_both, 1'b0);
        check({name, "_en_resp"},  o_en_at_resp, 1'b0);
        check({name, "_pready1"},  o_rdy_after, 1'b0);
        if (e_req > 0) begin
            check({name, "_prdata"}, o_prdata, e_prdata);
            check({name, "_addr"},   o_addr, a);
            if (wr) check({name, "_wdata"}, o_wdata, d);
            if (PSTRB_EN) check({name, "_wstrb"}, o_wstrb, wr ? strb : 4'h0);
        end
    endtask

    initial begin
        logic        wr;
        logic [31:0] a, d, rdv;
        logic [3:0]  strb;
        int          mode, delay;

        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = '0; bus.pwdata = '0;
`ifdef APB_BRIDGE_PSTRB_EN
        bus.pstrb = 4'hF;
`endif
        rdata = '0;
        clear_backend();

        // Reset state.
        #12;
        check("rst_wr_en",   wr_en, 1'b0);
        check("rst_rd_en",   rd_en, 1'b0);
        check("rst_pready",  bus.pready, 1'b0);
        check("rst_pslverr", bus.pslverr, 1'b0);
        check("rst_prdata",  bus.prdata, 32'h0);
        check("rst_addr",    addr, 32'h0);
        check("rst_wdata",   wdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Directed transfers.
        run_case("wr_zero_wait", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, M_ACK, 0, 32'h0);
        run_case("rd_3_stall",   1'b0, 32'h20, 32'h0,        4'hF, M_ACK, 3, 32'h12345678);

        // Abort during REQ: enables drop, no response, prdata keeps last read.
        @(negedge clk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 32'h40;
        @(negedge clk);
        bus.penable = 1'b1;
        check("abort_rd_en_on", rd_en, 1'b1);
        @(negedge clk);
        bus.psel = 1'b0; bus.penable = 1'b0;
        @(negedge clk);
        check("abort_rd_en_off", rd_en, 1'b0);
        check("abort_pready",    bus.pready, 1'b0);
        check("abort_prdata",    bus.prdata, 32'h12345678);
        @(negedge clk);
        check("abort_pready2",   bus.pready, 1'b0);
        $display("[TB] abort read addr=00000040 rd_en=%0d prdata=%08h", rd_en, bus.prdata);

        run_case("rd_timeout",  1'b0, 32'h24, 32'h0,        4'hF, M_NONE,  0, 32'h0);
        run_case("wr_misalign", 1'b1, 32'h13, 32'hCAFEF00D, 4'hF, M_ACK,   0, 32'h0);
        run_case("wr_ack_err",  1'b1, 32'h30, 32'h55AA55AA, 4'hF, M_BOTH,  1, 32'h0);
        run_case("rd_err",      1'b0, 32'h34, 32'h0,        4'hF, M_ERR,   2, 32'h0);
        run_case("rd_wrong_ack",1'b0, 32'h38, 32'h0,        4'hF, M_WRONG, 0, 32'h0);
        run_case("wr_ack_at_to",1'b1, 32'h3C, 32'h01020304, 4'hF, M_ACK,   TO, 32'h0);

        // Reset while in REQ clears everything without waiting for a clock edge.
        @(negedge clk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 32'h44; bus.pwdata = 32'h89ABCDEF;
        @(negedge clk);
        bus.penable = 1'b1;
        check("rstreq_wr_en_on", wr_en, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("rstreq_wr_en",  wr_en, 1'b0);
        check("rstreq_pready", bus.pready, 1'b0);
        check("rstreq_addr",   addr, 32'h0);
        check("rstreq_wdata",  wdata, 32'h0);
        $display("[TB] reset in REQ wr_en=%0d addr=%08h", wr_en, addr);
        @(negedge clk);
        bus.psel = 1'b0; bus.penable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_case("post_reset_rd", 1'b0, 32'h48, 32'h0, 4'hF, M_ACK, 1, 32'hA5A5_0F0F);

`ifdef APB_BRIDGE_PSTRB_EN
        run_case("wr_strb_0101", 1'b1, 32'h50, 32'h11223344, 4'b0101, M_ACK, 0, 32'h0);
        run_case("wr_strb_zero", 1'b1, 32'h54, 32'h99887766, 4'b0000, M_ACK, 0, 32'h0);
        run_case("rd_strb",      1'b0, 32'h58, 32'h0,        4'b1111, M_ACK, 0, 32'h0BADF00D);
`endif

        // Randomized transfers.
        for (int t = 0; t < 40; t++) begin
            wr = 1'($urandom_range(0, 1));
            a  = $urandom & 32'h0000_0FFC;
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            d     = $urandom;
            rdv   = $urandom;
            strb  = PSTRB_EN ? 4'($urandom_range(0, 15)) : 4'hF;
            mode  = $urandom_range(0, 4);
            delay = $urandom_range(0, 6);
            run_case($sformatf("rnd%0d", t), wr, a, d, strb, mode, delay, rdv);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
